// File: rtl/parc_core_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : parc_core_reorder_buffer                                   |
// | Description : In-order reorder buffer for the 5-stage PARC core.         |
// |               Decode allocates slots in program order, writeback fills   |
// |               them in any order, and the oldest filled entry commits to  |
// |               the register file, one per cycle. Two bypass read ports    |
// |               expose filled results to the operand bypass mux.           |
// | Ports       : clk, reset (sync, active-high)                             |
// |               rob_alloc_req_*/rob_alloc_resp_slot : allocation handshake |
// |               rob_fill_*                          : writeback fill       |
// |               rob_commit_*                        : register-file commit |
// |               rob_byp{0,1}_*                      : bypass lookups       |
// | Revision    : 1.0  initial release                                      |
// +--------------------------------------------------------------------------+
module parc_core_reorder_buffer #(
   parameter int ENTRIES = 16,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,

   input  logic                       rob_alloc_req_val,
   input  logic [4:0]                 rob_alloc_req_preg,
   output logic                       rob_alloc_req_rdy,
   output logic [$clog2(ENTRIES)-1:0] rob_alloc_resp_slot,

   input  logic                       rob_fill_val,
   input  logic [$clog2(ENTRIES)-1:0] rob_fill_slot,
   input  logic [DATA_W-1:0]          rob_fill_data,

   output logic                       rob_commit_wen,
   output logic [$clog2(ENTRIES)-1:0] rob_commit_slot,
   output logic [4:0]                 rob_commit_rf_waddr,
   output logic [DATA_W-1:0]          rob_commit_data,

   input  logic [$clog2(ENTRIES)-1:0] rob_byp0_slot,
   output logic [DATA_W-1:0]          rob_byp0_data,
   output logic                       rob_byp0_val,

   input  logic [$clog2(ENTRIES)-1:0] rob_byp1_slot,
   output logic [DATA_W-1:0]          rob_byp1_data,
   output logic                       rob_byp1_val
);

   localparam int                 c_SLOT_W = $clog2(ENTRIES);
   localparam int                 c_CNT_W  = $clog2(ENTRIES) + 1;
   localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(ENTRIES);
   localparam logic [ENTRIES-1:0] c_ONE    = {{(ENTRIES-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // Entry storage and queue pointers
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0]  r_valid;
   logic [ENTRIES-1:0]  r_pending;
   logic [4:0]          r_preg [ENTRIES];
   logic [DATA_W-1:0]   r_data [ENTRIES];

   logic [c_SLOT_W-1:0] r_head;
   logic [c_SLOT_W-1:0] r_tail;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_alloc_fire;
   logic                w_fill_ok;
   logic                w_commit;
   logic [ENTRIES-1:0]  w_alloc_sel;
   logic [ENTRIES-1:0]  w_fill_sel;
   logic [ENTRIES-1:0]  w_commit_sel;

   // ---------------------------------------------------------------------
   // Event qualification
   // ---------------------------------------------------------------------
   // Full is judged on the registered count only, so a commit in the same
   // cycle never frees a slot for allocation until the following cycle.
   assign rob_alloc_req_rdy = (r_count != c_FULL);
   assign w_alloc_fire      = rob_alloc_req_val && rob_alloc_req_rdy;

   // Fills to empty or already-written slots are dropped silently.
   assign w_fill_ok = rob_fill_val && r_valid[rob_fill_slot] && r_pending[rob_fill_slot];

   // Commit looks only at registered state: a fill landing on the head this
   // cycle makes it eligible on the next cycle.
   assign w_commit  = r_valid[r_head] && !r_pending[r_head];

   // One-hot slot selects keep the per-entry update loop free of index math.
   assign w_alloc_sel  = w_alloc_fire ? (c_ONE << r_tail)        : '0;
   assign w_fill_sel   = w_fill_ok    ? (c_ONE << rob_fill_slot) : '0;
   assign w_commit_sel = w_commit     ? (c_ONE << r_head)        : '0;

   // ---------------------------------------------------------------------
   // Entry state update
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= '0;
         r_pending <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_preg[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_alloc_sel[i]) begin
               // Allocation owns the slot outright; a fill aimed at a slot
               // not yet granted is meaningless and loses.
               r_valid[i]   <= 1'b1;
               r_pending[i] <= 1'b1;
               r_preg[i]    <= rob_alloc_req_preg;
            end else begin
               // Commit needs a filled entry and fill needs a pending one,
               // so the two never touch the same slot in one cycle.
               if (w_commit_sel[i]) begin
                  r_valid[i] <= 1'b0;
               end
               if (w_fill_sel[i]) begin
                  r_pending[i] <= 1'b0;
                  r_data[i]    <= rob_fill_data;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Head / tail / occupancy
   // ---------------------------------------------------------------------
   // Pointers wrap naturally because ENTRIES is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc_fire) begin
            r_tail <= r_tail + c_SLOT_W'(1);
         end
         if (w_commit) begin
            r_head <= r_head + c_SLOT_W'(1);
         end
         case ({w_alloc_fire, w_commit})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign rob_alloc_resp_slot = r_tail;

   assign rob_commit_wen      = w_commit;
   assign rob_commit_slot     = r_head;
   assign rob_commit_rf_waddr = r_preg[r_head];
   assign rob_commit_data     = r_data[r_head];

   // Bypass reads registered state only; a result filled this cycle shows
   // up on the bypass ports from the next cycle.
   assign rob_byp0_data = r_data[rob_byp0_slot];
   assign rob_byp0_val  = r_valid[rob_byp0_slot] && !r_pending[rob_byp0_slot];
   assign rob_byp1_data = r_data[rob_byp1_slot];
   assign rob_byp1_val  = r_valid[rob_byp1_slot] && !r_pending[rob_byp1_slot];

endmodule
`default_nettype wire

// File: tb/tb_parc_core_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_parc_core_reorder_buffer                                |
// | Description : Self-checking bench for parc_core_reorder_buffer. Keeps a  |
// |               program-order queue of in-flight instructions as the       |
// |               reference, compares every DUT output each cycle, and runs  |
// |               directed scenarios with literal expectations followed by a |
// |               randomized phase.                                          |
// | Revision    : 1.0  initial release                                      |
// +--------------------------------------------------------------------------+
module tb_parc_core_reorder_buffer;

   localparam int ENTRIES = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        rob_alloc_req_val;
   logic [4:0]  rob_alloc_req_preg;
   logic        rob_alloc_req_rdy;
   logic [3:0]  rob_alloc_resp_slot;
   logic        rob_fill_val;
   logic [3:0]  rob_fill_slot;
   logic [31:0] rob_fill_data;
   logic        rob_commit_wen;
   logic [3:0]  rob_commit_slot;
   logic [4:0]  rob_commit_rf_waddr;
   logic [31:0] rob_commit_data;
   logic [3:0]  rob_byp0_slot;
   logic [31:0] rob_byp0_data;
   logic        rob_byp0_val;
   logic [3:0]  rob_byp1_slot;
   logic [31:0] rob_byp1_data;
   logic        rob_byp1_val;

   always #5 clk = ~clk;

   parc_core_reorder_buffer #(.ENTRIES(16), .DATA_W(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .rob_alloc_req_val   (rob_alloc_req_val),
      .rob_alloc_req_preg  (rob_alloc_req_preg),
      .rob_alloc_req_rdy   (rob_alloc_req_rdy),
      .rob_alloc_resp_slot (rob_alloc_resp_slot),
      .rob_fill_val        (rob_fill_val),
      .rob_fill_slot       (rob_fill_slot),
      .rob_fill_data       (rob_fill_data),
      .rob_commit_wen      (rob_commit_wen),
      .rob_commit_slot     (rob_commit_slot),
      .rob_commit_rf_waddr (rob_commit_rf_waddr),
      .rob_commit_data     (rob_commit_data),
      .rob_byp0_slot       (rob_byp0_slot),
      .rob_byp0_data       (rob_byp0_data),
      .rob_byp0_val        (rob_byp0_val),
      .rob_byp1_slot       (rob_byp1_slot),
      .rob_byp1_data       (rob_byp1_data),
      .rob_byp1_val        (rob_byp1_val)
   );

   // ---------------------------------------------------------------------
   // Reference: in-flight instructions, oldest first
   // ---------------------------------------------------------------------
   typedef struct {
      logic [3:0]  slot;
      logic [4:0]  preg;
      bit          filled;
      logic [31:0] data;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] m_head = 4'd0;
   logic [3:0] m_tail = 4'd0;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
   endtask

   function automatic int find_slot(input logic [3:0] s);
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].slot == s) return i;
      return -1;
   endfunction

   // Advance the reference at each edge from the inputs present at that edge.
   always @(posedge clk) begin : model_upd
      bit   do_commit;
      bit   do_alloc;
      int   k;
      ent_t e;
      if (reset) begin
         mq.delete();
         m_head = 4'd0;
         m_tail = 4'd0;
      end else begin
         do_commit = (mq.size() > 0) && mq[0].filled;
         do_alloc  = rob_alloc_req_val && (mq.size() < ENTRIES);
         if (rob_fill_val) begin
            k = find_slot(rob_fill_slot);
            if (k >= 0 && !mq[k].filled) begin
               e = mq[k];
               e.filled = 1'b1;
               e.data   = rob_fill_data;
               mq[k]    = e;
            end
         end
         if (do_commit) begin
            void'(mq.pop_front());
            m_head = m_head + 4'd1;
         end
         if (do_alloc) begin
            e.slot   = m_tail;
            e.preg   = rob_alloc_req_preg;
            e.filled = 1'b0;
            e.data   = 32'h0;
            mq.push_back(e);
            m_tail = m_tail + 4'd1;
         end
      end
   end

   // Compare every DUT output against the reference mid-cycle.
   always @(negedge clk) begin : compare
      bit exp_wen;
      bit exp_val;
      int k;
      if (cmp_en) begin
         check("rdy", 32'(rob_alloc_req_rdy), 32'(mq.size() < ENTRIES));
         check("resp_slot", 32'(rob_alloc_resp_slot), 32'(m_tail));
         exp_wen = (mq.size() > 0) && mq[0].filled;
         check("commit_wen", 32'(rob_commit_wen), 32'(exp_wen));
         check("commit_slot", 32'(rob_commit_slot), 32'(m_head));
         if (exp_wen) begin
            check("commit_waddr", 32'(rob_commit_rf_waddr), 32'(mq[0].preg));
            check("commit_data", rob_commit_data, mq[0].data);
         end
         k = find_slot(rob_byp0_slot);
         exp_val = (k >= 0) && mq[k].filled;
         check("byp0_val", 32'(rob_byp0_val), 32'(exp_val));
         if (exp_val) check("byp0_data", rob_byp0_data, mq[k].data);
         k = find_slot(rob_byp1_slot);
         exp_val = (k >= 0) && mq[k].filled;
         check("byp1_val", 32'(rob_byp1_val), 32'(exp_val));
         if (exp_val) check("byp1_data", rob_byp1_data, mq[k].data);
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [4:0] preg);
      rob_alloc_req_val  = 1'b1;
      rob_alloc_req_preg = preg;
   endtask

   task automatic fill(input logic [3:0] slot, input logic [31:0] data);
      rob_fill_val  = 1'b1;
      rob_fill_slot = slot;
      rob_fill_data = data;
   endtask

   int cand[$];

   initial begin
      reset              = 1'b1;
      rob_alloc_req_val  = 1'b0;
      rob_alloc_req_preg = 5'd0;
      rob_fill_val       = 1'b0;
      rob_fill_slot      = 4'd0;
      rob_fill_data      = 32'h0;
      rob_byp0_slot      = 4'd0;
      rob_byp1_slot      = 4'd0;
      tick();
      tick();
      cmp_en = 1'b1;
      reset  = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_rdy", 32'(rob_alloc_req_rdy), 32'd1);
      check("rst_resp_slot", 32'(rob_alloc_resp_slot), 32'd0);
      check("rst_commit_wen", 32'(rob_commit_wen), 32'd0);
      check("rst_commit_slot", 32'(rob_commit_slot), 32'd0);
      check("rst_commit_waddr", 32'(rob_commit_rf_waddr), 32'd0);
      check("rst_commit_data", rob_commit_data, 32'd0);
      check("rst_byp0_val", 32'(rob_byp0_val), 32'd0);
      check("rst_byp0_data", rob_byp0_data, 32'd0);
      check("rst_byp1_val", 32'(rob_byp1_val), 32'd0);

      // Allocate preg 3,4,5 then fill slot 0
      tick(); alloc(5'd3);
      @(negedge clk); check("t1_slot0", 32'(rob_alloc_resp_slot), 32'd0);
      tick(); alloc(5'd4);
      @(negedge clk); check("t1_slot1", 32'(rob_alloc_resp_slot), 32'd1);
      tick(); alloc(5'd5);
      @(negedge clk); check("t1_slot2", 32'(rob_alloc_resp_slot), 32'd2);
      tick(); rob_alloc_req_val = 1'b0; fill(4'd0, 32'h11);
      @(negedge clk); check("t1_no_commit_yet", 32'(rob_commit_wen), 32'd0);
      // Out-of-order: slot 2 fills before slot 1
      tick(); fill(4'd2, 32'h33);
      @(negedge clk);
      check("t1_commit_wen", 32'(rob_commit_wen), 32'd1);
      check("t1_commit_slot", 32'(rob_commit_slot), 32'd0);
      check("t1_commit_waddr", 32'(rob_commit_rf_waddr), 32'd3);
      check("t1_commit_data", rob_commit_data, 32'h11);
      tick(); fill(4'd1, 32'h22);
      @(negedge clk); check("t2_blocked", 32'(rob_commit_wen), 32'd0);
      tick(); rob_fill_val = 1'b0;
      @(negedge clk);
      check("t2_c1_wen", 32'(rob_commit_wen), 32'd1);
      check("t2_c1_slot", 32'(rob_commit_slot), 32'd1);
      check("t2_c1_waddr", 32'(rob_commit_rf_waddr), 32'd4);
      check("t2_c1_data", rob_commit_data, 32'h22);
      tick();
      @(negedge clk);
      check("t2_c2_slot", 32'(rob_commit_slot), 32'd2);
      check("t2_c2_data", rob_commit_data, 32'h33);
      tick();
      @(negedge clk); check("t2_drained", 32'(rob_commit_wen), 32'd0);

      // Fill the buffer from reset, then free one slot and wrap the tail
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         alloc(5'(i));
         tick();
      end
      rob_alloc_req_val = 1'b0;
      fill(4'd0, 32'hA5);
      @(negedge clk);
      check("t3_full_rdy", 32'(rob_alloc_req_rdy), 32'd0);
      tick(); rob_fill_val = 1'b0;
      @(negedge clk);
      check("t3_commit_wen", 32'(rob_commit_wen), 32'd1);
      check("t3_rdy_during_commit", 32'(rob_alloc_req_rdy), 32'd0);
      tick();
      @(negedge clk);
      check("t3_rdy_after", 32'(rob_alloc_req_rdy), 32'd1);
      check("t3_wrap_slot", 32'(rob_alloc_resp_slot), 32'd0);
      alloc(5'd9);
      tick(); rob_alloc_req_val = 1'b0;
      @(negedge clk); check("t3_refull", 32'(rob_alloc_req_rdy), 32'd0);

      // Alloc and commit in the same cycle with 5 in flight
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         alloc(5'(i + 1));
         tick();
      end
      rob_alloc_req_val = 1'b0;
      fill(4'd0, 32'h44);
      tick(); rob_fill_val = 1'b0; alloc(5'd6);
      @(negedge clk);
      check("t4_wen", 32'(rob_commit_wen), 32'd1);
      check("t4_resp_slot", 32'(rob_alloc_resp_slot), 32'd5);
      tick(); rob_alloc_req_val = 1'b0;
      @(negedge clk);
      check("t4_head", 32'(rob_commit_slot), 32'd1);
      check("t4_tail", 32'(rob_alloc_resp_slot), 32'd6);
      // Count stayed 5: exactly 11 more allocations fill it.
      for (int i = 0; i < 10; i++) begin
         alloc(5'(i));
         tick();
      end
      rob_alloc_req_val = 1'b0;
      @(negedge clk); check("t4_not_full_at_15", 32'(rob_alloc_req_rdy), 32'd1);
      alloc(5'd7);
      tick(); rob_alloc_req_val = 1'b0;
      @(negedge clk); check("t4_full_at_16", 32'(rob_alloc_req_rdy), 32'd0);

      // Bypass visibility one cycle after fill
      tick();
      rob_byp0_slot = 4'd7; rob_byp1_slot = 4'd7;
      fill(4'd7, 32'hDEADBEEF);
      @(negedge clk); check("t5_byp0_val_same_cycle", 32'(rob_byp0_val), 32'd0);
      tick(); rob_fill_val = 1'b0;
      @(negedge clk);
      check("t5_byp0_val", 32'(rob_byp0_val), 32'd1);
      check("t5_byp0_data", rob_byp0_data, 32'hDEADBEEF);
      check("t5_byp1_data", rob_byp1_data, 32'hDEADBEEF);

      // Reset with entries in flight
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      @(negedge clk);
      check("t6_rdy", 32'(rob_alloc_req_rdy), 32'd1);
      check("t6_resp_slot", 32'(rob_alloc_resp_slot), 32'd0);
      check("t6_wen", 32'(rob_commit_wen), 32'd0);
      check("t6_byp0_val", 32'(rob_byp0_val), 32'd0);
      check("t6_byp1_val", 32'(rob_byp1_val), 32'd0);

      // Randomized traffic checked by the compare process
      for (int n = 0; n < 4000; n++) begin
         tick();
         reset              = ($urandom_range(0, 399) == 0);
         rob_alloc_req_val  = ($urandom_range(0, 99) < 60);
         rob_alloc_req_preg = 5'($urandom);
         rob_byp0_slot      = 4'($urandom);
         rob_byp1_slot      = 4'($urandom);
         cand.delete();
         for (int i = 0; i < mq.size(); i++)
            if (!mq[i].filled) cand.push_back(int'(mq[i].slot));
         if (cand.size() > 0 && $urandom_range(0, 99) < 55)
            fill(4'(cand[$urandom_range(0, cand.size() - 1)]), $urandom);
         else
            rob_fill_val = 1'b0;
      end

      tick();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
